bomb_controller: RTL and testbench

Drop-and-detonate controller for the player's bomb: on a drop request it latches a tile-aligned bomb position from the player's location and runs a fuse timer. On expiry it emits the single-cycle explosion pulse and explosion coordinates consumed by every enemy instance and by the player-death logic. It also drives the bomb/blast pixel overlay for the top-level VGA mux, and sits between the player movement block and the enemy blocks.

---
 rtl/bomb_controller.sv | 128 ++++++++++++
 tb/tb_bomb_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bomb_controller.sv
// Bomb drop/fuse/blast controller: snaps the bomb to the tile grid, times the fuse and blast,
// emits a one-cycle explosion pulse and drives the bomb/blast pixel overlay.
module bomb_controller #(
   parameter int TICK_CYCLES = 25_000_000,
   parameter int FUSE_TICKS  = 3,
   parameter int BLAST_TICKS = 2,
   parameter int MIN_X       = 143,
   parameter int MIN_Y       = 34
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        drop,
   input  logic        game_over,
   input  logic [9:0]  b_x,
   input  logic [9:0]  b_y,
   input  logic [9:0]  v_x,
   input  logic [9:0]  v_y,
   output logic [9:0]  e_x,
   output logic [9:0]  e_y,
   output logic        explosion_SCEN,
   output logic        bomb_active,
   output logic        bomb_on,
   output logic        blast_on,
   output logic [11:0] rgb_out
);

   localparam int PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int TMAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [TW-1:0] FUSE_LAST  = TW'(FUSE_TICKS - 1);
   localparam logic [TW-1:0] BLAST_LAST = TW'(BLAST_TICKS - 1);
   localparam logic [9:0]    MIN_X10    = 10'(MIN_X);
   localparam logic [9:0]    MIN_Y10    = 10'(MIN_Y);
   localparam logic [11:0]   BOMB_RGB   = 12'h000;
   localparam logic [11:0]   BLAST_RGB  = 12'hF80;

   typedef enum logic [1:0] {IDLE, ARMED, BLAST} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [TW-1:0] ticks;
   logic [9:0]    clamp_x, clamp_y, snap_x, snap_y;
   logic [10:0]   ex11, ey11, vx11, vy11;
   logic          h_arm, v_arm;

   // Clamp into the play area first so the offset subtraction never underflows, then round to 16px.
   always_comb begin
      clamp_x = (b_x > MIN_X10) ? b_x : MIN_X10;
      clamp_y = (b_y > MIN_Y10) ? b_y : MIN_Y10;
      snap_x  = MIN_X10 + (((clamp_x - MIN_X10) + 10'd8) & ~10'd15);
      snap_y  = MIN_Y10 + (((clamp_y - MIN_Y10) + 10'd8) & ~10'd15);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         e_x            <= '0;
         e_y            <= '0;
         presc          <= '0;
         ticks          <= '0;
         explosion_SCEN <= 1'b0;
      end else begin
         explosion_SCEN <= 1'b0;
         case (state)
            IDLE: begin
               if (drop && !game_over) begin
                  state <= ARMED;
                  e_x   <= snap_x;
                  e_y   <= snap_y;
                  presc <= '0;
                  ticks <= '0;
               end
            end
            ARMED: begin
               if (game_over) begin
                  state <= IDLE;
               end else if (presc == PRESC_LAST) begin
                  presc <= '0;
                  if (ticks == FUSE_LAST) begin
                     state          <= BLAST;
                     ticks          <= '0;
                     explosion_SCEN <= 1'b1;
                  end else begin
                     ticks <= ticks + 1'b1;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            BLAST: begin
               if (presc == PRESC_LAST) begin
                  presc <= '0;
                  if (ticks == BLAST_LAST) begin
                     state <= IDLE;
                     ticks <= '0;
                  end else begin
                     ticks <= ticks + 1'b1;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Overlay geometry uses 11-bit sums so the tile and arm extents never wrap at the screen edge.
   always_comb begin
      ex11  = {1'b0, e_x};
      ey11  = {1'b0, e_y};
      vx11  = {1'b0, v_x};
      vy11  = {1'b0, v_y};
      h_arm = (vy11 >= ey11) && (vy11 <= ey11 + 11'd15) &&
              (vx11 + 11'd48 >= ex11) && (vx11 <= ex11 + 11'd63);
      v_arm = (vx11 >= ex11) && (vx11 <= ex11 + 11'd15) &&
              (vy11 + 11'd48 >= ey11) && (vy11 <= ey11 + 11'd63);
      bomb_active = (state != IDLE);
      bomb_on     = (state == ARMED) &&
                    (vx11 >= ex11) && (vx11 <= ex11 + 11'd15) &&
                    (vy11 >= ey11) && (vy11 <= ey11 + 11'd15);
      blast_on    = (state == BLAST) && (h_arm || v_arm);
      rgb_out     = blast_on ? BLAST_RGB : (bomb_on ? BOMB_RGB : 12'h000);
   end

endmodule

// File: tb/tb_bomb_controller.sv
// Scoreboard bench for bomb_controller: expected explosions are queued at drop time and
// matched by a monitor on every explosion pulse; state and overlay are checked directly.
module tb_bomb_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        drop = 1'b0;
   logic        game_over = 1'b0;
   logic [9:0]  b_x = '0, b_y = '0, v_x = '0, v_y = '0;
   logic [9:0]  e_x, e_y;
   logic        explosion_SCEN, bomb_active, bomb_on, blast_on;
   logic [11:0] rgb_out;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      int         at;
   } expl_t;

   expl_t sb[$];
   expl_t mon_e;
   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    k;

   bomb_controller #(
      .TICK_CYCLES(4), .FUSE_TICKS(3), .BLAST_TICKS(2), .MIN_X(143), .MIN_Y(34)
   ) dut (
      .clk(clk), .reset(reset), .drop(drop), .game_over(game_over),
      .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
      .e_x(e_x), .e_y(e_y), .explosion_SCEN(explosion_SCEN),
      .bomb_active(bomb_active), .bomb_on(bomb_on), .blast_on(blast_on),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic applyStimulus(input logic d, input logic go, input logic [9:0] bx, input logic [9:0] by);
      drop      = d;
      game_over = go;
      b_x       = bx;
      b_y       = by;
   endtask

   task automatic waitCycle(input int base, input int n);
      while (cyc < base + n) @(negedge clk);
   endtask

   task automatic overlayPoint(input string name, input logic [9:0] px, input logic [9:0] py,
                               input logic eb, input logic el, input logic [11:0] ergb);
      v_x = px;
      v_y = py;
      #1;
      checkOutput({name, "_bomb_on"}, bomb_on, eb);
      checkOutput({name, "_blast_on"}, blast_on, el);
      checkOutput({name, "_rgb"}, rgb_out, ergb);
      @(negedge clk);
   endtask

   // Every explosion pulse must match the oldest queued expectation, including its cycle.
   always @(negedge clk) begin
      if (reset === 1'b1 && explosion_SCEN === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL pulse_unexpected: explosion at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("pulse_cycle", cyc, mon_e.at);
            checkOutput("pulse_e_x", e_x, mon_e.x);
            checkOutput("pulse_e_y", e_y, mon_e.y);
         end
      end
   end

   initial begin
      #100000;
      fails++;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("reset_e_x", e_x, 10'd0);
      checkOutput("reset_e_y", e_y, 10'd0);
      checkOutput("reset_pulse", explosion_SCEN, 1'b0);
      checkOutput("reset_active", bomb_active, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // Basic drop, ignored drops, overlay and re-arm on a held drop
      k = cyc;
      applyStimulus(1'b1, 1'b0, 10'd200, 10'd100);
      sb.push_back('{x: 10'd207, y: 10'd98, at: k + 13});
      waitCycle(k, 1);
      drop = 1'b0;
      checkOutput("armed_e_x", e_x, 10'd207);
      checkOutput("armed_e_y", e_y, 10'd98);
      checkOutput("armed_active", bomb_active, 1'b1);
      overlayPoint("bomb_tl", 10'd207, 10'd98, 1'b1, 1'b0, 12'h000);
      overlayPoint("bomb_br", 10'd222, 10'd113, 1'b1, 1'b0, 12'h000);
      overlayPoint("bomb_right_out", 10'd223, 10'd98, 1'b0, 1'b0, 12'h000);
      overlayPoint("bomb_below_out", 10'd207, 10'd114, 1'b0, 1'b0, 12'h000);
      waitCycle(k, 5);
      applyStimulus(1'b1, 1'b0, 10'd300, 10'd300);
      waitCycle(k, 6);
      drop = 1'b0;
      waitCycle(k, 12);
      checkOutput("armed_last_active", bomb_active, 1'b1);
      waitCycle(k, 13);
      drop = 1'b1;
      waitCycle(k, 14);
      drop = 1'b0;
      checkOutput("blast_e_x_kept", e_x, 10'd207);
      checkOutput("blast_e_y_kept", e_y, 10'd98);
      overlayPoint("blast_left_end", 10'd159, 10'd105, 1'b0, 1'b1, 12'hF80);
      overlayPoint("blast_right_end", 10'd270, 10'd105, 1'b0, 1'b1, 12'hF80);
      overlayPoint("blast_top_end", 10'd210, 10'd50, 1'b0, 1'b1, 12'hF80);
      overlayPoint("blast_bottom_end", 10'd210, 10'd161, 1'b0, 1'b1, 12'hF80);
      overlayPoint("blast_left_out", 10'd158, 10'd105, 1'b0, 1'b0, 12'h000);
      overlayPoint("blast_corner_out", 10'd230, 10'd130, 1'b0, 1'b0, 12'h000);
      waitCycle(k, 20);
      checkOutput("blast_last_active", bomb_active, 1'b1);
      applyStimulus(1'b1, 1'b0, 10'd151, 10'd34);
      waitCycle(k, 21);
      checkOutput("idle_after_blast", bomb_active, 1'b0);
      checkOutput("idle_e_x_kept", e_x, 10'd207);
      sb.push_back('{x: 10'd159, y: 10'd34, at: k + 34});
      waitCycle(k, 22);
      drop = 1'b0;
      checkOutput("rearm_active", bomb_active, 1'b1);
      checkOutput("rearm_e_x_roundup", e_x, 10'd159);
      checkOutput("rearm_e_y", e_y, 10'd34);
      waitCycle(k, 42);
      checkOutput("rearm_done_idle", bomb_active, 1'b0);

      // Clamp to play-area corner, then abort by game_over; no pulse may follow
      @(negedge clk);
      k = cyc;
      applyStimulus(1'b1, 1'b0, 10'd140, 10'd30);
      waitCycle(k, 1);
      drop = 1'b0;
      checkOutput("clamp_e_x", e_x, 10'd143);
      checkOutput("clamp_e_y", e_y, 10'd34);
      waitCycle(k, 5);
      game_over = 1'b1;
      waitCycle(k, 6);
      game_over = 1'b0;
      checkOutput("abort_idle", bomb_active, 1'b0);
      checkOutput("abort_e_x_kept", e_x, 10'd143);
      waitCycle(k, 26);
      checkOutput("abort_still_idle", bomb_active, 1'b0);
      applyStimulus(1'b1, 1'b1, 10'd200, 10'd100);
      waitCycle(k, 27);
      checkOutput("gameover_drop_blocked", bomb_active, 1'b0);
      checkOutput("gameover_e_x_kept", e_x, 10'd143);
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);

      // Asynchronous reset landing on the pulse cycle
      @(negedge clk);
      k = cyc;
      applyStimulus(1'b1, 1'b0, 10'd200, 10'd100);
      waitCycle(k, 1);
      drop = 1'b0;
      waitCycle(k, 12);
      @(posedge clk);
      #1;
      checkOutput("pulse_before_reset", explosion_SCEN, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("async_reset_pulse", explosion_SCEN, 1'b0);
      checkOutput("async_reset_active", bomb_active, 1'b0);
      checkOutput("async_reset_e_x", e_x, 10'd0);
      checkOutput("async_reset_e_y", e_y, 10'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("post_reset_idle", bomb_active, 1'b0);

      checkOutput("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
